matrix_operand_sequencer: RTL and testbench

MATRIX_OPERAND_SEQUENCER -- requirements
Module: matrix_operand_sequencer

---
 rtl/matrix_operand_sequencer.sv | 108 ++++++++++
 tb/tb_matrix_operand_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_sequencer.sv
// Streams a 4x4 matrix and a 4-element pixel vector as 16 (a, b) operand beats
// to a downstream multiplier, with hold stalls and a completion handshake.
module matrix_operand_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mat_we,
    input  logic [3:0]        mat_addr,
    input  logic              vec_we,
    input  logic [1:0]        vec_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              start,
    input  logic              hold,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              a_tvalid,
    output logic              b_tvalid,
    input  logic              done_matrixmult,
    output logic              busy,
    output logic              seq_done
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic [DATA_W-1:0] mat [16];
    logic [DATA_W-1:0] vec [4];
    logic [DATA_W-1:0] a_next, b_next;
    logic [DATA_W-1:0] mat0_fwd, vec0_fwd;
    logic              tvalid_next, seq_done_next;

    // Beat 0 is registered on the same edge as an IDLE write, so forward it.
    assign mat0_fwd = (mat_we && mat_addr == 4'd0) ? wdata : mat[0];
    assign vec0_fwd = (vec_we && vec_addr == 2'd0) ? wdata : vec[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mat[i] <= '0;
            for (int i = 0; i < 4; i++)  vec[i] <= '0;
        end else if (state == IDLE) begin
            if (mat_we) mat[mat_addr] <= wdata;
            if (vec_we) vec[vec_addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            a        <= '0;
            b        <= '0;
            a_tvalid <= 1'b0;
            b_tvalid <= 1'b0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            a        <= a_next;
            b        <= b_next;
            a_tvalid <= tvalid_next;
            b_tvalid <= tvalid_next;
            busy     <= (state_next != IDLE);
            seq_done <= seq_done_next;
        end
    end

    // cnt holds the index of the next beat to issue; beat 0 leaves from IDLE.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        a_next        = a;
        b_next        = b;
        tvalid_next   = 1'b0;
        seq_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = STREAM;
                    a_next      = mat0_fwd;
                    b_next      = vec0_fwd;
                    tvalid_next = 1'b1;
                    cnt_next    = 4'd1;
                end
            end
            STREAM: begin
                if (!hold) begin
                    a_next      = mat[cnt];
                    b_next      = vec[cnt[1:0]];
                    tvalid_next = 1'b1;
                    cnt_next    = cnt + 4'd1;
                    if (cnt == 4'd15) state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_matrixmult) begin
                    state_next    = IDLE;
                    seq_done_next = 1'b1;
                    cnt_next      = 4'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Randomized self-checking bench: a scoreboard of expected operand beats
// derived from the stored matrix/vector contents and the handshake rules.
module tb_matrix_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mat_we = 1'b0;
    logic [3:0]  mat_addr = '0;
    logic        vec_we = 1'b0;
    logic [1:0]  vec_addr = '0;
    logic [31:0] wdata = '0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] a, b;
    logic        a_tvalid, b_tvalid;
    logic        done_matrixmult = 1'b0;
    logic        busy, seq_done;

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] mdl_m [16];
    logic [31:0] mdl_v [4];

    matrix_operand_sequencer #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .mat_we(mat_we), .mat_addr(mat_addr),
        .vec_we(vec_we), .vec_addr(vec_addr),
        .wdata(wdata), .start(start), .hold(hold),
        .a(a), .b(b), .a_tvalid(a_tvalid), .b_tvalid(b_tvalid),
        .done_matrixmult(done_matrixmult), .busy(busy), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_mat(input int idx, input logic [31:0] d);
        mat_we = 1'b1; mat_addr = 4'(idx); wdata = d;
        step();
        mat_we = 1'b0;
        mdl_m[idx] = d;
    endtask

    task automatic write_vec(input int idx, input logic [31:0] d);
        vec_we = 1'b1; vec_addr = 2'(idx); wdata = d;
        step();
        vec_we = 1'b0;
        mdl_v[idx] = d;
    endtask

    task automatic start_product(input bit with_write, input logic [31:0] d);
        start = 1'b1;
        if (with_write) begin
            mat_we = 1'b1; mat_addr = 4'd0; wdata = d;
        end
        step();
        start = 1'b0; mat_we = 1'b0;
        if (with_write) mdl_m[0] = d;
    endtask

    // Called one cycle after start was sampled; beat 0 should be visible now.
    task automatic run_product(input int hold_after, input int hold_len, input int disturb_at,
                               input int done_delay, input bit start_with_done);
        int beat = 0;
        int cyc = 0;
        int hold_left = 0;
        logic [31:0] last_a = 'x;
        logic [31:0] last_b = 'x;
        while (beat < 16 && cyc < 60) begin
            if (a_tvalid) begin
                check_val("beat_a", a, mdl_m[beat]);
                check_val("beat_b", b, mdl_v[beat % 4]);
                last_a = a; last_b = b;
                beat++;
            end else begin
                check_val("hold_a", a, last_a);
                check_val("hold_b", b, last_b);
            end
            check_val("tvalid_pair", 32'(b_tvalid), 32'(a_tvalid));
            check_val("busy_stream", 32'(busy), 1);
            hold = 1'b0; mat_we = 1'b0; start = 1'b0; done_matrixmult = 1'b0;
            if (a_tvalid && beat == hold_after + 1) hold_left = hold_len;
            if (hold_left > 0) begin
                hold = 1'b1;
                hold_left--;
            end
            if (a_tvalid && beat == disturb_at + 1) begin
                mat_we = 1'b1; mat_addr = 4'd0; wdata = 32'h0;
                start = 1'b1; done_matrixmult = 1'b1;
            end
            if (beat < 16) begin
                step();
                cyc++;
            end
        end
        check_val("beat_count", beat, 16);
        check_val("stream_len", cyc, 15 + hold_len);
        step();
        check_val("tvalid_after", 32'(a_tvalid), 0);
        check_val("busy_wait", 32'(busy), 1);
        check_val("seq_done_wait", 32'(seq_done), 0);
        for (int i = 0; i < done_delay; i++) begin
            step();
            check_val("wait_tvalid", 32'(a_tvalid), 0);
            check_val("wait_busy", 32'(busy), 1);
        end
        done_matrixmult = 1'b1; start = start_with_done;
        step();
        done_matrixmult = 1'b0; start = 1'b0;
        check_val("seq_done_pulse", 32'(seq_done), 1);
        check_val("busy_done", 32'(busy), 0);
        step();
        check_val("seq_done_once", 32'(seq_done), 0);
        check_val("busy_idle", 32'(busy), 0);
        check_val("tvalid_idle", 32'(a_tvalid), 0);
    endtask

    initial begin
        int vis;
        for (int i = 0; i < 16; i++) mdl_m[i] = '0;
        for (int i = 0; i < 4; i++)  mdl_v[i] = '0;

        reset = 1'b1;
        step(); step();
        check_val("rst_a", a, 0);
        check_val("rst_b", b, 0);
        check_val("rst_tvalid", 32'(a_tvalid), 0);
        check_val("rst_btvalid", 32'(b_tvalid), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_seq_done", 32'(seq_done), 0);
        reset = 1'b0;
        step();

        // basic
        write_mat(0, 32'h4124CCCD); write_mat(1, 32'h40C80000);
        write_mat(2, 32'h40A9999A); write_mat(3, 32'h3C4CCCCD);
        for (int i = 4; i < 16; i++) write_mat(i, $urandom);
        write_vec(0, 32'hBF07AE14); write_vec(1, 32'h4141999A);
        write_vec(2, 32'hC1691EB8); write_vec(3, 32'h4040A3D7);
        start_product(1'b0, '0);
        run_product(99, 0, 99, 2, 1'b0);

        // hold after beat 5
        start_product(1'b0, '0);
        run_product(5, 3, 99, 1, 1'b0);

        // done/write/start during stream, late done with coincident start
        start_product(1'b0, '0);
        run_product(99, 0, 4, 7, 1'b1);

        // write and start in the same cycle; beat 0 also proves M[0][0] survived
        start_product(1'b1, $urandom);
        run_product(99, 0, 99, 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) write_mat(i, $urandom);
            for (int i = 0; i < 4; i++)  write_vec(i, $urandom);
            start_product(1'b0, '0);
            run_product($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 14),
                        $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        // reset abort at beat 9, with competing start/write/hold
        start_product(1'b0, '0);
        vis = 0;
        for (int c = 0; c < 40 && vis < 10; c++) begin
            if (a_tvalid) vis++;
            if (vis < 10) step();
        end
        check_val("abort_reach", vis, 10);
        check_val("abort_beat9_a", a, mdl_m[9]);
        reset = 1'b1; start = 1'b1; hold = 1'b1;
        mat_we = 1'b1; mat_addr = 4'd3; wdata = $urandom | 32'h1;
        step();
        reset = 1'b0; start = 1'b0; hold = 1'b0; mat_we = 1'b0;
        check_val("abort_tvalid", 32'(a_tvalid), 0);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_a", a, 0);
        check_val("abort_b", b, 0);
        for (int i = 0; i < 16; i++) mdl_m[i] = '0;
        for (int i = 0; i < 4; i++)  mdl_v[i] = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("abort_no_seq_done", 32'(seq_done), 0);
            check_val("abort_idle", 32'(busy), 0);
        end
        start_product(1'b0, '0);
        run_product(99, 0, 99, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
